// File: rtl/fp_normround.sv
// rtl/fp_normround.sv - 2-stage normalize and round-to-nearest-even stage of the FP add/sub datapath.
// Optional ovf/unf/inexact flag ports are enabled by defining FP_NORMROUND_FLAGS_EN.
module fp_normround #(
  parameter  int width = 27,
  parameter  int ew    = 8,
  localparam int fw    = width - 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [width-1:0] res,
  input  logic          carry,
  input  logic [ew-1:0] exp_in,
  input  logic          sign_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign_out,
  output logic [ew-1:0] exp_out,
  output logic [fw-1:0] frac_out
`ifdef FP_NORMROUND_FLAGS_EN
  ,
  output logic          ovf,
  output logic          unf,
  output logic          inexact
`endif
);

  localparam int lw = $clog2(width + 1);
  localparam int xw = ew + 2;
  localparam logic signed [xw-1:0] one  = 1;
  localparam logic signed [xw-1:0] emax = xw'((1 << ew) - 1);

  logic             s1_valid, s1_adv;
  logic [width-1:0] s1_res;
  logic             s1_carry, s1_sign;
  logic [ew-1:0]    s1_exp;
  logic [lw-1:0]    s1_lzc, lzc_in;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  always_comb begin
    lzc_in = lw'(width);
    for (int i = 0; i < width; i++)
      if (res[i]) lzc_in = lw'(width - 1 - i);
  end

  logic [width-1:0]       norm;
  logic signed [xw-1:0]   e_in_x, lzc_x, e_pre, e_fin;
  logic [fw-1:0]          frac_r;
  logic                   is_zero, is_unf, is_ovf, inc, rc;
  logic                   n_sign;
  logic [ew-1:0]          n_exp;
  logic [fw-1:0]          n_frac;

  assign e_in_x = $signed({2'b00, s1_exp});
  assign lzc_x  = $signed({{(xw-lw){1'b0}}, s1_lzc});

  always_comb begin
    norm    = '0;
    e_pre   = '0;
    is_zero = 1'b0;
    is_unf  = 1'b0;
    if (s1_carry) begin
      // Right shift by one keeps the dropped bit alive in sticky.
      norm    = {1'b1, s1_res[width-1:1]};
      norm[0] = s1_res[1] | s1_res[0];
      e_pre   = e_in_x + one;
    end else if (s1_res == '0) begin
      is_zero = 1'b1;
    end else if (e_in_x <= lzc_x) begin
      is_unf = 1'b1;
    end else begin
      norm  = s1_res << s1_lzc;
      e_pre = e_in_x - lzc_x;
    end
    inc    = norm[2] & (norm[1] | norm[0] | norm[3]);
    frac_r = norm[width-2:3] + fw'(inc);
    rc     = inc & (&norm[width-1:3]);
    e_fin  = e_pre + $signed({{(xw-1){1'b0}}, rc});
    is_ovf = !is_zero && !is_unf && (e_fin >= emax);
    n_sign = is_zero ? 1'b0 : s1_sign;
    if (is_zero || is_unf) begin
      n_exp  = '0;
      n_frac = '0;
    end else if (is_ovf) begin
      n_exp  = '1;
      n_frac = '0;
    end else begin
      n_exp  = e_fin[ew-1:0];
      n_frac = frac_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s1_carry  <= 1'b0;
      s1_exp    <= '0;
      s1_sign   <= 1'b0;
      s1_lzc    <= '0;
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      frac_out  <= '0;
`ifdef FP_NORMROUND_FLAGS_EN
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inexact   <= 1'b0;
`endif
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_res   <= res;
          s1_carry <= carry;
          s1_exp   <= exp_in;
          s1_sign  <= sign_in;
          s1_lzc   <= lzc_in;
        end
      end
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sign_out <= n_sign;
          exp_out  <= n_exp;
          frac_out <= n_frac;
`ifdef FP_NORMROUND_FLAGS_EN
          ovf      <= is_ovf;
          unf      <= is_unf;
          inexact  <= (|norm[2:0]) | is_ovf | is_unf;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_normround.sv
// tb/tb_fp_normround.sv - scoreboard bench for fp_normround against an arithmetic RNE reference model.
module tb_fp_normround;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] res = '0;
  logic        carry = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        sign_in = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] frac_out;
  logic        ovf, unf, inexact;
  logic        or_man = 1'b1, or_rnd = 1'b1, rand_mode = 1'b0;

  assign out_ready = rand_mode ? or_rnd : or_man;

`ifndef FP_NORMROUND_FLAGS_EN
  assign ovf = 1'b0;
  assign unf = 1'b0;
  assign inexact = 1'b0;
`endif

  fp_normround dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .carry(carry), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
    .exp_out(exp_out), .frac_out(frac_out)
`ifdef FP_NORMROUND_FLAGS_EN
    , .ovf(ovf), .unf(unf), .inexact(inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic        o, u, x;
  } res_t;

  res_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Value = {carry,res} * 2^(exp_in-26); rounded to 24 significant bits, ties to even.
  function automatic res_t model(input logic [26:0] r, input logic c, input logic [7:0] e, input logic s);
    res_t o;
    logic [63:0] v, q, rem, half;
    int p, en, sh;
    o = '0;
    v = {36'd0, c, r};
    if (v == 0) return o;
    p = 0;
    for (int i = 0; i < 28; i++) if (v[i]) p = i;
    en = int'(e) + p - 26;
    o.s = s;
    if (en <= 0) begin
      o.u = 1'b1;
      o.x = 1'b1;
      return o;
    end
    sh = p - 23;
    if (sh > 0) begin
      q = v >> sh;
      rem = v & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      o.x = (rem != 0);
    end else begin
      q = v << (-sh);
    end
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      en++;
    end
    if (en >= 255) begin
      o.e = 8'hFF;
      o.o = 1'b1;
      o.x = 1'b1;
    end else begin
      o.e = en[7:0];
      o.f = q[22:0];
    end
    return o;
  endfunction

  always @(negedge clk)
    if (rst_n && in_valid && in_ready) sb.push_back(model(res, carry, exp_in, sign_in));

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got exp %0h frac %0h, expected no output", exp_out, frac_out);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sign_out", 64'(sign_out), 64'(e.s));
        chk("exp_out", 64'(exp_out), 64'(e.e));
        chk("frac_out", 64'(frac_out), 64'(e.f));
`ifdef FP_NORMROUND_FLAGS_EN
        chk("flags_ovf_unf_inexact", 64'({ovf, unf, inexact}), 64'({e.o, e.u, e.x}));
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1 or_rnd = ($urandom_range(0, 9) < 7);
  end

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic send(input logic [26:0] r, input logic c, input logic [7:0] e, input logic s);
    logic ok;
    res = r; carry = c; exp_in = e; sign_in = s; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    or_man = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    res_t snap;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({sign_out, exp_out, frac_out, ovf, unf, inexact}), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(27'h4000000, 1'b0, 8'd127, 1'b1);
    send(27'h0000000, 1'b1, 8'd127, 1'b0);
    send(27'h0000000, 1'b1, 8'd254, 1'b0);
    send(27'h0000008, 1'b0, 8'd127, 1'b0);
    send(27'h0000008, 1'b0, 8'd10, 1'b1);
    send(27'h0000000, 1'b0, 8'd77, 1'b1);
    send(27'h4000004, 1'b0, 8'd127, 1'b0);
    send(27'h400000C, 1'b0, 8'd127, 1'b0);
    send(27'h7FFFFFC, 1'b0, 8'd127, 1'b0);
    send(27'h4000001, 1'b0, 8'd255, 1'b1);
    send(27'h2000000, 1'b0, 8'd0, 1'b0);
    send(27'h7FFFFFF, 1'b1, 8'd1, 1'b1);
    send(27'h7FFFFFC, 1'b0, 8'd254, 1'b0);
    drain();

    or_man = 1'b0;
    send(27'h4000010, 1'b0, 8'd100, 1'b0);
    send(27'h0123456, 1'b0, 8'd120, 1'b1);
    res = 27'h5555555; carry = 1'b1; exp_in = 8'd90; in_valid = 1'b1;
    @(negedge clk);
    snap = {sign_out, exp_out, frac_out, ovf, unf, inexact};
    for (int k = 0; k < 4; k++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({sign_out, exp_out, frac_out, ovf, unf, inexact}), 64'(snap));
      @(negedge clk);
    end
    @(posedge clk);
    #1 or_man = 1'b1;
    send(27'h5555555, 1'b1, 8'd90, 1'b0);
    send(27'h000000F, 1'b0, 8'd200, 1'b1);
    drain();

    or_man = 1'b0;
    send(27'h4000000, 1'b0, 8'd50, 1'b0);
    send(27'h4000000, 1'b0, 8'd51, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    #4 rst_n = 1'b1;
    or_man = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [26:0] r;
      r = 27'($urandom()) >> $urandom_range(0, 27);
      send(r, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'($urandom()));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_mode = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
